// File: rtl/ibuf_loader_if.sv
//----------------------------------------------------------------------------
// ibuf_loader_if
//
// Bundles the load stream, load status and PE read port of the instruction
// buffer writer.
//
//   master : drives loadStart/loadCount, inData/inValid, rdAddr/noStall;
//            observes inReady, loadBusy, loadDone, dataOut.
//   slave  : the ibuf_loader side (mirror of master).
//
// Optional: IBUF_LOAD_CHECKSUM_EN adds loadChecksum (XOR of the words
// written by the current load).
//----------------------------------------------------------------------------
interface ibuf_loader_if #(
    parameter int addrLen = 5,
    parameter int dataLen = 32,
    parameter int busLen  = 8
);
    logic                 loadStart;
    logic [addrLen:0]     loadCount;
    logic [busLen-1:0]    inData;
    logic                 inValid;
    logic                 inReady;
    logic                 loadBusy;
    logic                 loadDone;
    logic [addrLen-1:0]   rdAddr;
    logic                 noStall;
    logic [dataLen-1:0]   dataOut;
`ifdef IBUF_LOAD_CHECKSUM_EN
    logic [dataLen-1:0]   loadChecksum;
`endif

    modport master (
        output loadStart, loadCount, inData, inValid, rdAddr, noStall,
        input  inReady, loadBusy, loadDone, dataOut
`ifdef IBUF_LOAD_CHECKSUM_EN
        , input loadChecksum
`endif
    );

    modport slave (
        input  loadStart, loadCount, inData, inValid, rdAddr, noStall,
        output inReady, loadBusy, loadDone, dataOut
`ifdef IBUF_LOAD_CHECKSUM_EN
        , output loadChecksum
`endif
    );
endinterface

// File: rtl/ibuf_loader.sv
//----------------------------------------------------------------------------
// ibuf_loader
//
// Writer side of a PE instruction buffer. A narrow valid/ready beat stream
// is packed little-endian (first beat in the low bits) into dataLen-bit
// words which are written sequentially into a (1<<addrLen)-deep RAM. The
// PE reads the RAM through a registered, stall-gated port.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : ibuf_loader_if.slave
//            loadStart/loadCount  start a load of min(loadCount, depth) words
//            inData/inValid/inReady  beat stream (accept = inValid & inReady)
//            loadBusy             high while loading
//            loadDone             one-cycle pulse when the load completes
//            rdAddr/noStall       read request; dataOut updates only if noStall
//            dataOut              registered instruction word
//
// Optional: define IBUF_LOAD_CHECKSUM_EN to add bus.loadChecksum.
// peId identifies the PE for debug only and has no functional effect.
//----------------------------------------------------------------------------
module ibuf_loader #(
    parameter int addrLen = 5,
    parameter int dataLen = 32,
    parameter int busLen  = 8,
    parameter int peId    = 1
) (
    input logic          clk,
    input logic          reset,
    ibuf_loader_if.slave bus
);
    localparam int BPW   = dataLen / busLen;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << addrLen;

    localparam logic [addrLen:0] DEPTH_W   = {1'b1, {addrLen{1'b0}}};
    localparam logic [addrLen:0] ONE_W     = {{addrLen{1'b0}}, 1'b1};
    localparam logic [BCW-1:0]   BEAT_LAST = BCW'(BPW - 1);

    if ((dataLen % busLen) != 0 || peId < 0) begin : g_param_check
        $error("ibuf_loader: dataLen must be a multiple of busLen and peId >= 0");
    end

    typedef enum logic {IDLE, LOAD} state_t;

    state_t               state;
    logic                 inReadyQ;
    logic                 loadBusyQ;
    logic                 loadDoneQ;
    logic [dataLen-1:0]   dataOutQ;
    logic [addrLen-1:0]   wrAddr;
    logic [addrLen-1:0]   lastAddr;     // index of the final word of this load
    logic [BCW-1:0]       beatCnt;
    logic [dataLen-1:0]   shiftReg;     // beat-slotted word assembly register
    logic [dataLen-1:0]   assembled;    // shiftReg with the current beat merged in
    logic [addrLen:0]     clamped;
    logic                 accept;
    logic                 wordDone;
`ifdef IBUF_LOAD_CHECKSUM_EN
    logic [dataLen-1:0]   checksum;
`endif

    logic [dataLen-1:0]   mem [DEPTH];

    // NOTE: every variable written here gets a full default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        clamped   = (bus.loadCount > DEPTH_W) ? DEPTH_W : bus.loadCount;
        assembled = shiftReg;
        assembled[beatCnt*busLen +: busLen] = bus.inData;
    end

    assign accept   = (state == LOAD) && bus.inValid && inReadyQ;
    // The BPW-th beat completes a word; it is written on this same edge
    // using the merged value, so the last beat never sits in shiftReg.
    assign wordDone = accept && (beatCnt == BEAT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            inReadyQ  <= 1'b0;
            loadBusyQ <= 1'b0;
            loadDoneQ <= 1'b0;
            wrAddr    <= '0;
            lastAddr  <= '0;
            beatCnt   <= '0;
            shiftReg  <= '0;
`ifdef IBUF_LOAD_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            loadDoneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.loadStart) begin
                        wrAddr   <= '0;
                        beatCnt  <= '0;
                        lastAddr <= addrLen'(clamped - ONE_W);
`ifdef IBUF_LOAD_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (clamped == '0) begin
                            loadDoneQ <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            inReadyQ  <= 1'b1;
                            loadBusyQ <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // loadStart is deliberately not examined here.
                    if (accept) begin
                        shiftReg <= assembled;
                        if (wordDone) begin
                            beatCnt <= '0;
                            wrAddr  <= wrAddr + addrLen'(1);
`ifdef IBUF_LOAD_CHECKSUM_EN
                            checksum <= checksum ^ assembled;
`endif
                            if (wrAddr == lastAddr) begin
                                state     <= IDLE;
                                inReadyQ  <= 1'b0;
                                loadBusyQ <= 1'b0;
                                loadDoneQ <= 1'b1;
                            end
                        end else begin
                            beatCnt <= beatCnt + BCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM has no reset; contents persist across reset so words
    // already loaded stay valid, and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wordDone) begin
            mem[wrAddr] <= assembled;
        end
    end

    // Read and write sample on the same edge, so a read of the address
    // being written returns the previous contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOutQ <= '0;
        end else if (bus.noStall) begin
            dataOutQ <= mem[bus.rdAddr];
        end
    end

    assign bus.inReady  = inReadyQ;
    assign bus.loadBusy = loadBusyQ;
    assign bus.loadDone = loadDoneQ;
    assign bus.dataOut  = dataOutQ;
`ifdef IBUF_LOAD_CHECKSUM_EN
    assign bus.loadChecksum = checksum;
`endif

endmodule

// File: tb/tb_ibuf_loader.sv
//----------------------------------------------------------------------------
// tb_ibuf_loader
//
// Self-checking bench for ibuf_loader. The stimulus process drives loads
// and reads and pushes expected results into queues; a monitor pops and
// compares whenever the DUT presents a read result or a loadDone pulse.
// The reference RAM is a plain array updated with whole words built from
// beats by shifting (first beat in the low bits).
//----------------------------------------------------------------------------
module tb_ibuf_loader;
    localparam int AL    = 5;
    localparam int DL    = 32;
    localparam int BL    = 8;
    localparam int BPW   = DL / BL;
    localparam int DEPTH = 1 << AL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ibuf_loader_if #(.addrLen(AL), .dataLen(DL), .busLen(BL)) bus ();

    ibuf_loader #(.addrLen(AL), .dataLen(DL), .busLen(BL), .peId(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DL-1:0] model_mem [DEPTH];
    logic [DL-1:0] load_words [$];
    logic [DL-1:0] csum_model;
    int            done_q [$];
    logic [DL-1:0] rd_q [$];
    logic          rd_fire = 1'b0;
    logic [DL-1:0] mon_exp;
    int            mon_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string msg);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", msg, $time);
    endtask

    // Cycle count and read-fire flag, both as seen at each rising edge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_fire <= bus.noStall && !reset;
    end

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_q.size() == 0) begin
                fail($sformatf("rd_unexpected actual=%0h required=no read", bus.dataOut));
            end else begin
                mon_exp = rd_q.pop_front();
                check("rd_data", bus.dataOut, mon_exp);
            end
        end
        if (bus.loadDone === 1'b1) begin
            if (done_q.size() == 0) begin
                fail($sformatf("done_unexpected actual=pulse@%0d required=none", cyc));
            end else begin
                mon_cyc = done_q.pop_front();
                check("done_cycle", cyc, mon_cyc);
            end
        end else if (done_q.size() > 0 && done_q[0] < cyc) begin
            mon_cyc = done_q.pop_front();
            fail($sformatf("done_missing actual=none required=pulse@%0d", mon_cyc));
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send_beat(input logic [BL-1:0] beat, input bit last, output bit ok);
        bus.inData  = beat;
        bus.inValid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("busy_in_load", bus.loadBusy, 1);
            if (bus.inReady === 1'b1) begin
                if (last) done_q.push_back(cyc + 1);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.inValid = 1'b0;
        if (!ok) fail("beat_timeout actual=inReady low required=beat accepted");
    endtask

    // gap_mode: 0 none, 1 idle cycle before every beat, 2 random idles.
    // coll_addr: word whose final beat coincides with a read of that address.
    // max_beats: stop after this many beats (negative = whole load).
    task automatic do_load(input int count, input int gap_mode, input int coll_addr,
                           input int max_beats);
        int n;
        int sent;
        bit ok;
        bit gap;
        logic [DL-1:0] w_word;
        n    = (count > DEPTH) ? DEPTH : count;
        sent = 0;
        bus.loadCount = (AL+1)'(count);
        bus.loadStart = 1'b1;
        if (n == 0) done_q.push_back(cyc + 1);
        @(posedge clk); #1;
        bus.loadStart = 1'b0;
        bus.loadCount = '0;
        csum_model = '0;
        if (n == 0) return;
        for (int w = 0; w < n; w++) begin
            w_word = load_words[w];
            for (int b = 0; b < BPW; b++) begin
                if (max_beats >= 0 && sent == max_beats) return;
                gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
                if (gap) begin
                    bus.inValid = 1'b0;
                    if (gap_mode == 1 && w == 0 && b == 2) begin
                        // A start request mid-load must be ignored.
                        bus.loadStart = 1'b1;
                        bus.loadCount = '0;
                    end
                    @(negedge clk);
                    check("busy_gap", bus.loadBusy, 1);
                    @(posedge clk); #1;
                    bus.loadStart = 1'b0;
                end
                if (w == coll_addr && b == BPW - 1) begin
                    bus.rdAddr  = AL'(w);
                    bus.noStall = 1'b1;
                    rd_q.push_back(model_mem[w]);
                end
                send_beat(w_word[b*BL +: BL], (w == n - 1) && (b == BPW - 1), ok);
                bus.noStall = 1'b0;
                if (!ok) return;
                sent++;
                if (b == BPW - 1) begin
                    model_mem[w] = w_word;
                    csum_model   = csum_model ^ w_word;
                end
            end
        end
        // loadDone cycle
        @(negedge clk);
        check("ready_after_done", bus.inReady, 0);
        check("busy_after_done", bus.loadBusy, 0);
`ifdef IBUF_LOAD_CHECKSUM_EN
        check("checksum", bus.loadChecksum, csum_model);
`endif
        @(posedge clk); #1;
    endtask

    task automatic rd(input int a);
        bus.rdAddr  = AL'(a);
        bus.noStall = 1'b1;
        rd_q.push_back(model_mem[a]);
        @(posedge clk); #1;
        bus.noStall = 1'b0;
    endtask

    task automatic fill_random(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.loadStart = 1'b0;
        bus.loadCount = '0;
        bus.inData    = '0;
        bus.inValid   = 1'b0;
        bus.rdAddr    = '0;
        bus.noStall   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_inReady", bus.inReady, 0);
        check("rst_loadBusy", bus.loadBusy, 0);
        check("rst_loadDone", bus.loadDone, 0);
        check("rst_dataOut", bus.dataOut, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic load: 0x11..0x88, two words
        load_words = '{32'h44332211, 32'h88776655};
        do_load(2, 0, -1, -1);
        rd(0);
        rd(1);

        // Stall: dataOut holds while rdAddr moves to 1
        rd(0);
        bus.rdAddr = AL'(1);
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", bus.dataOut, model_mem[0]);
            @(posedge clk); #1;
        end
        rd(1);

        // Gapped stream with a stray loadStart mid-load
        do_load(2, 1, -1, -1);
        rd(0);
        rd(1);

        // Zero-length load
        do_load(0, 0, -1, -1);
        @(negedge clk);
        check("zero_ready", bus.inReady, 0);
        check("zero_busy", bus.loadBusy, 0);
`ifdef IBUF_LOAD_CHECKSUM_EN
        check("zero_checksum", bus.loadChecksum, 0);
`endif
        @(posedge clk); #1;
        rd(0);
        rd(1);

        // Reset mid-load after 6 beats of a 3-word load
        fill_random(3);
        do_load(3, 0, -1, 6);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_inReady", bus.inReady, 0);
        check("mid_rst_loadBusy", bus.loadBusy, 0);
        check("mid_rst_loadDone", bus.loadDone, 0);
        check("mid_rst_dataOut", bus.dataOut, 0);
`ifdef IBUF_LOAD_CHECKSUM_EN
        check("mid_rst_checksum", bus.loadChecksum, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rd(0);
        rd(1);

        // Fresh load after reset
        fill_random(3);
        do_load(3, 2, -1, -1);
        for (int a = 0; a < 3; a++) rd(a);

        // Read/write collision on address 1
        fill_random(1);
        load_words.push_back(32'hDEADBEEF);
        do_load(2, 0, 1, -1);
        rd(1);
        rd(0);

        // Clamp: request 40 words into a 32-deep RAM
        fill_random(40);
        do_load(40, 0, -1, -1);
        bus.inData  = BL'($urandom);
        bus.inValid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("clamp_no_ready", bus.inReady, 0);
            @(posedge clk); #1;
        end
        bus.inValid = 1'b0;
        for (int a = 0; a < DEPTH; a++) rd(a);

        // Random loads with random gaps and random reads
        repeat (4) begin
            int cnt;
            cnt = $urandom_range(1, 6);
            fill_random(cnt);
            do_load(cnt, 2, -1, -1);
            repeat (6) rd($urandom_range(0, DEPTH - 1));
        end

        repeat (4) @(posedge clk);
        #1;
        check("rd_queue_drained", rd_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibuf_loader.md
Name: ibuf_loader

Overview:
- Writer side of the PE instruction buffer.
- Accepts a narrow valid/ready instruction stream from the memory interface and packs busLen-bit beats into dataLen-bit instruction words.
- Writes packed words sequentially into a (1<<addrLen)-deep instruction RAM.
- Serves the PE compute pipeline through a registered read port with stall gating.
- Replaces ROM-only instruction initialisation with a runtime load per PE.

Parameters:
- addrLen, 5, instruction RAM address width; depth = 1<<addrLen.
- dataLen, 32, instruction word width; must be an integer multiple of busLen.
- busLen, 8, stream beat width; beats per word BPW = dataLen/busLen.
- peId, 1, PE index; carried for debug display only, no functional effect.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- loadStart  in  1  one-cycle pulse that begins a load.
- loadCount  in  addrLen+1  number of words to load; sampled with loadStart.
- inData  in  busLen  stream beat.
- inValid  in  1  beat valid.
- inReady  out  1  beat accepted when inValid && inReady.
- loadBusy  out  1  high while in LOAD.
- loadDone  out  1  one-cycle pulse at load completion.
- rdAddr  in  addrLen  PE read address.
- noStall  in  1  read enable.
- dataOut  out  dataLen  registered instruction word.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, inReady 0, loadBusy 0, loadDone 0, dataOut 0, word/beat counters 0, shift register 0.
- RAM contents are not reset.
- States: IDLE, LOAD.
- IDLE:
  - inReady 0.
  - On loadStart, latch cnt = min(loadCount, 1<<addrLen) and clear wrAddr and beat counter to 0.
  - If cnt == 0: stay in IDLE and pulse loadDone the next cycle.
  - Otherwise go to LOAD.
- LOAD:
  - inReady 1 and loadBusy 1.
  - Each accepted beat fills the shift register; the first beat of a word lands in bits [busLen-1:0] (little-endian beat order).
  - On the BPW-th beat, the assembled word (including the current beat) is written to mem[wrAddr] on that same clock edge; wrAddr increments and the beat counter clears.
  - After the word with wrAddr == cnt-1 is written: go to IDLE, pulse loadDone for 1 cycle, deassert inReady from the next cycle.
  - Beats with inValid=0 hold all state. No timeout.
- loadStart during LOAD is ignored.
- wrAddr does not wrap past the depth, because cnt is clamped.
- Reset mid-load returns to IDLE immediately:
  - the partial word is discarded;
  - words already written remain;
  - no loadDone pulse.
- Read port:
  - If noStall, dataOut <= mem[rdAddr] at the clock edge (1-cycle latency).
  - If noStall=0, dataOut holds.
  - Reads are allowed in any state.
- Simultaneous read and write to the same address: dataOut gets the old contents (read-before-write).

Optional Feature:
- Macro IBUF_LOAD_CHECKSUM_EN.
- When defined:
  - Adds output port loadChecksum [dataLen-1:0], which is the XOR of all words written in the current load.
  - Cleared to 0 on reset and on an accepted loadStart.
  - Updated on the same edge as each RAM write.
  - Stable and valid from the loadDone cycle until the next loadStart.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic load: loadCount=2; beats 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with inValid held high. Required: loadDone pulses once, 1 cycle after the 8th beat. Reading rdAddr=0 then rdAddr=1 with noStall=1 gives dataOut 0x44332211, then 0x88776655.
- Gapped stream: same data as the basic load with inValid toggling every other cycle. Required: identical RAM contents, and loadBusy held until the last beat.
- Zero and clamp: loadCount=0 gives loadDone 1 cycle after loadStart with no RAM writes. loadCount=40 (depth 32) writes exactly 32 words; inReady drops after beat 128.
- Stall: noStall=0 while rdAddr changes from 0 to 1. Required: dataOut holds 0x44332211; it updates to 0x88776655 one cycle after noStall rises.
- Reset mid-load: loadCount=3; assert reset after 6 beats. Required: mem[0]=word0 retained, no loadDone, inReady=0, dataOut=0. A fresh load then completes normally.
- Read/write collision: read address 1 on the same edge as the write of mem[1]=0xDEADBEEF. Required: dataOut shows old data; the next read shows 0xDEADBEEF. With IBUF_LOAD_CHECKSUM_EN defined, loadChecksum equals the XOR of the loaded words.
